// File: rtl/branch_predictor.sv
// Dynamic branch predictor: bimodal or gshare 2-bit counters, direct-mapped BTB,
// and resolved/mispredicted branch counters. Lookup is combinational; training happens in ID.
module branch_predictor #(
    parameter int ADDR_W      = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int GHR_BITS    = 0,
    localparam int GH         = (GHR_BITS > 0) ? GHR_BITS : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              predict_taken_o,
    output logic [ADDR_W-1:0] predict_target_o,
    output logic [GH-1:0]     predict_ghr_o,
    input  logic              update_valid_i,
    input  logic [ADDR_W-1:0] update_pc_i,
    input  logic [GH-1:0]     update_ghr_i,
    input  logic              update_taken_i,
    input  logic [ADDR_W-1:0] update_target_i,
    input  logic              update_mispredict_i,
    output logic [31:0]       update_count_o,
    output logic [31:0]       mispredict_count_o
);

    localparam int BHT_W = $clog2(BHT_ENTRIES);
    localparam int BTB_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_W - BTB_W - 2;

    logic [1:0]             ctr_q        [BHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
    logic [ADDR_W-1:0]      btb_target_q [BTB_ENTRIES];
    logic [GH-1:0]          ghr_q, ghr_d;
    logic [31:0]            update_count_q, mispredict_count_q;
    logic [1:0]             ctr_d;

    logic [BHT_W-1:0] lk_hist, up_hist, lk_bidx, up_bidx;
    logic [BTB_W-1:0] lk_tidx, up_tidx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit;
    logic             unused_ok;

    // Bimodal builds carry a 1-bit history port that is held at zero and never hashed in.
    generate
        if (GHR_BITS > 0) begin : g_gshare
            assign lk_hist = BHT_W'(ghr_q);
            assign up_hist = BHT_W'(update_ghr_i);
            assign ghr_d   = GH'({ghr_q, update_taken_i});
        end else begin : g_bimodal
            assign lk_hist = '0;
            assign up_hist = '0;
            assign ghr_d   = '0;
        end
    endgenerate

    assign lk_bidx = lookup_pc_i[BHT_W+1:2] ^ lk_hist;
    assign up_bidx = update_pc_i[BHT_W+1:2] ^ up_hist;
    assign lk_tidx = lookup_pc_i[BTB_W+1:2];
    assign up_tidx = update_pc_i[BTB_W+1:2];
    assign lk_tag  = lookup_pc_i[ADDR_W-1:BTB_W+2];
    assign up_tag  = update_pc_i[ADDR_W-1:BTB_W+2];

    // Reads registered state only, so a same-cycle update is seen one cycle later.
    assign lk_hit             = btb_valid_q[lk_tidx] && (btb_tag_q[lk_tidx] == lk_tag);
    assign predict_taken_o    = lk_hit && ctr_q[lk_bidx][1];
    assign predict_target_o   = lk_hit ? btb_target_q[lk_tidx] : '0;
    assign predict_ghr_o      = ghr_q;
    assign update_count_o     = update_count_q;
    assign mispredict_count_o = mispredict_count_q;

    assign unused_ok = ^{lookup_pc_i[1:0], update_pc_i[1:0], update_ghr_i};

    // NOTE: every path assigns ctr_d after its default, so no latch is inferred.
    always_comb begin
        ctr_d = ctr_q[up_bidx];
        if (update_taken_i) begin
            if (ctr_d != 2'b11) ctr_d = ctr_d + 2'b01;
        end else begin
            if (ctr_d != 2'b00) ctr_d = ctr_d - 2'b01;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= 2'b01;
            btb_valid_q        <= '0;
            ghr_q              <= '0;
            update_count_q     <= '0;
            mispredict_count_q <= '0;
        end else if (update_valid_i) begin
            ctr_q[up_bidx] <= ctr_d;
            if (update_taken_i) btb_valid_q[up_tidx] <= 1'b1;
            ghr_q          <= ghr_d;
            update_count_q <= update_count_q + 32'd1;
            if (update_mispredict_i) mispredict_count_q <= mispredict_count_q + 32'd1;
        end
    end

    // NOTE: BTB tag/target storage has no reset; the valid bits alone gate its use.
    always_ff @(posedge clk_i) begin
        if (rst_i && update_valid_i && update_taken_i) begin
            btb_tag_q[up_tidx]    <= up_tag;
            btb_target_q[up_tidx] <= update_target_i;
        end
    end

endmodule
